// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the regfile write-port arbiter: writeback select
// encodings, register address width and the derived drain mode.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] WB_ZERO = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    typedef enum logic [1:0] {
        MODE_EMPTY = 2'b00,
        MODE_HOLD  = 2'b01,
        MODE_FORCE = 2'b10
    } drain_mode_t;

    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = 32'(1) << rd;
        rd_onehot[0] = 1'b0;
    endfunction

endpackage

// File: rtl/wb_slow_fifo.sv
// DEPTH-entry {rd, data} FIFO for slow-unit results; exposes head, occupancy
// and the OR of one-hot destinations of all live entries.
module wb_slow_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [REG_ADDR_W-1:0]      push_rd,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    output logic [REG_ADDR_W-1:0]      head_rd,
    output logic [XLEN-1:0]            head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                mask
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DEPTH-1:0]      valid;
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]       data_mem [DEPTH];

    // Control state is reset; payload storage is qualified by valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) mask = mask | rd_onehot(rd_mem[i]);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, slow-unit
// results are buffered and drained into idle slots or forced when starved.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [1:0]            pipe_wb_sel,
    input  logic [XLEN-1:0]       pipe_alu,
    input  logic [XLEN-1:0]       pipe_mem,
    input  logic [XLEN-1:0]       pipe_pc4,
    output logic                  pipe_stall,
    input  logic                  slow_valid,
    input  logic [REG_ADDR_W-1:0] slow_rd,
    input  logic [XLEN-1:0]       slow_data,
    output logic                  slow_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [31:0]           pending_mask
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]         count;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  push;
    logic                  pop;
    logic [AW-1:0]         age;
    logic                  pipe_wr;
    logic [XLEN-1:0]       pipe_data;
    drain_mode_t           mode;

    wb_slow_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (slow_rd),
        .push_data (slow_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (count),
        .mask      (pending_mask)
    );

    assign pipe_wr    = pipe_valid && pipe_we && (pipe_rd != '0);
    // Ready from registered occupancy only; x0 results are swallowed here.
    assign slow_ready = !rst && (count < CW'(DEPTH));
    assign push       = slow_valid && slow_ready && (slow_rd != '0);

    always_comb begin
        unique case (pipe_wb_sel)
            WB_ALU:  pipe_data = pipe_alu;
            WB_MEM:  pipe_data = pipe_mem;
            WB_PC4:  pipe_data = pipe_pc4;
            default: pipe_data = '0;
        endcase
    end

    always_comb begin
        if (count == '0)
            mode = MODE_EMPTY;
        else if (count == CW'(DEPTH) || age >= AW'(STARVE_LIMIT))
            mode = MODE_FORCE;
        else
            mode = MODE_HOLD;
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_rd      = '0;
        rf_wdata   = '0;
        pipe_stall = 1'b0;
        pop        = 1'b0;
        if (!rst) begin
            if (mode == MODE_FORCE) begin
                rf_we      = 1'b1;
                rf_rd      = head_rd;
                rf_wdata   = head_data;
                pop        = 1'b1;
                pipe_stall = pipe_wr;
            end else if (pipe_wr) begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_data;
            end else if (mode == MODE_HOLD) begin
                rf_we    = 1'b1;
                rf_rd    = head_rd;
                rf_wdata = head_data;
                pop      = 1'b1;
            end
        end
    end

    // Head wait time; restarts whenever the head changes or the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            age <= '0;
        else if (pop || count == '0)
            age <= '0;
        else if (age < AW'(STARVE_LIMIT))
            age <= age + 1'b1;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe writes, slow drains, starvation,
// full FIFO, x0 handling and asynchronous reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [1:0]  pipe_wb_sel;
    logic [63:0] pipe_alu;
    logic [63:0] pipe_mem;
    logic [63:0] pipe_pc4;
    logic        pipe_stall;
    logic        slow_valid;
    logic [4:0]  slow_rd;
    logic [63:0] slow_data;
    logic        slow_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN         (64),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_valid   (pipe_valid),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_wb_sel  (pipe_wb_sel),
        .pipe_alu     (pipe_alu),
        .pipe_mem     (pipe_mem),
        .pipe_pc4     (pipe_pc4),
        .pipe_stall   (pipe_stall),
        .slow_valid   (slow_valid),
        .slow_rd      (slow_rd),
        .slow_data    (slow_data),
        .slow_ready   (slow_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [4:0] rd, input logic [63:0] alu);
        pipe_valid  = 1'b1;
        pipe_we     = 1'b1;
        pipe_rd     = rd;
        pipe_wb_sel = 2'b01;
        pipe_alu    = alu;
    endtask

    task automatic slow_offer(input logic v, input logic [4:0] rd, input logic [63:0] d);
        slow_valid = v;
        slow_rd    = rd;
        slow_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wb_sel = '0;
        pipe_alu = 64'h1234; pipe_mem = 64'h5555_AAAA; pipe_pc4 = 64'h8004;
        slow_valid = 1'b0; slow_rd = '0; slow_data = '0;

        tick();
        check("rst_slow_ready", slow_ready, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_stall", pipe_stall, 0);
        check("rst_mask", pending_mask, 0);
        tick();
        rst = 1'b0;
        #1;
        check("idle_slow_ready", slow_ready, 1);
        check("idle_rf_we", rf_we, 0);

        // pipe only, all four select encodings
        pipe_write(5'd5, 64'h1234);
        #1;
        check("pipe_we", rf_we, 1);
        check("pipe_rd", rf_rd, 5);
        check("pipe_alu", rf_wdata, 64'h1234);
        check("pipe_nostall", pipe_stall, 0);
        pipe_wb_sel = 2'b00; #1;
        check("pipe_zero", rf_wdata, 0);
        pipe_wb_sel = 2'b10; #1;
        check("pipe_mem", rf_wdata, 64'h5555_AAAA);
        pipe_wb_sel = 2'b11; #1;
        check("pipe_pc4", rf_wdata, 64'h8004);
        pipe_valid = 1'b0; #1;
        check("pipe_invalid", rf_we, 0);
        check("idle_rd", rf_rd, 0);

        // slow result alone
        slow_offer(1'b1, 5'd7, 64'hDEAD);
        #1;
        check("slow_ready0", slow_ready, 1);
        check("slow_nobypass", rf_we, 0);
        tick();
        slow_offer(1'b0, 5'd0, 64'h0);
        #1;
        check("slow_we", rf_we, 1);
        check("slow_rd", rf_rd, 7);
        check("slow_data", rf_wdata, 64'hDEAD);
        check("slow_mask", pending_mask, 32'h0000_0080);
        tick();
        check("slow_mask_clr", pending_mask, 0);
        check("slow_idle", rf_we, 0);

        // starvation under continuous pipe writes
        pipe_write(5'd3, 64'h3333);
        slow_offer(1'b1, 5'd9, 64'h99);
        tick();
        slow_offer(1'b0, 5'd0, 64'h0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("starve_wait%0d_stall", c), pipe_stall, 0);
            check($sformatf("starve_wait%0d_rd", c), rf_rd, 3);
            tick();
        end
        #1;
        check("starve_stall", pipe_stall, 1);
        check("starve_rd", rf_rd, 9);
        check("starve_data", rf_wdata, 64'h99);
        tick();
        check("starve_resume_stall", pipe_stall, 0);
        check("starve_resume_rd", rf_rd, 3);
        check("starve_mask", pending_mask, 0);

        // two entries fill the FIFO under continuous pipe writes
        slow_offer(1'b1, 5'd10, 64'hA0);
        tick();
        slow_offer(1'b1, 5'd11, 64'hB0);
        #1;
        check("full_ready_1", slow_ready, 1);
        check("full_pipe_wins", rf_rd, 3);
        tick();
        slow_offer(1'b0, 5'd0, 64'h0);
        #1;
        check("full_not_ready", slow_ready, 0);
        check("full_mask", pending_mask, 32'h0000_0C00);
        check("full_stall", pipe_stall, 1);
        check("full_drain_rd", rf_rd, 10);
        check("full_drain_data", rf_wdata, 64'hA0);
        tick();
        check("full_ready_again", slow_ready, 1);
        check("full_after_stall", pipe_stall, 0);
        check("full_after_rd", rf_rd, 3);
        check("full_after_mask", pending_mask, 32'h0000_0800);
        pipe_valid = 1'b0;
        #1;
        check("idle_drain_rd", rf_rd, 11);
        check("idle_drain_data", rf_wdata, 64'hB0);
        tick();
        check("drained_mask", pending_mask, 0);
        check("drained_we", rf_we, 0);

        // x0 destinations
        pipe_write(5'd0, 64'h77);
        #1;
        check("x0_pipe_we", rf_we, 0);
        pipe_valid = 1'b0;
        slow_offer(1'b1, 5'd0, 64'hFF);
        #1;
        check("x0_slow_ready", slow_ready, 1);
        tick();
        slow_offer(1'b0, 5'd0, 64'h0);
        #1;
        check("x0_slow_we", rf_we, 0);
        check("x0_slow_mask", pending_mask, 0);
        check("x0_slow_ready_after", slow_ready, 1);

        // asynchronous reset with two buffered entries
        pipe_write(5'd3, 64'h3333);
        slow_offer(1'b1, 5'd12, 64'hC0);
        tick();
        slow_offer(1'b1, 5'd13, 64'hD0);
        tick();
        slow_offer(1'b0, 5'd0, 64'h0);
        #1;
        check("arst_pre_mask", pending_mask, 32'h0000_3000);
        #1;
        rst = 1'b1;
        #1;
        check("arst_slow_ready", slow_ready, 0);
        check("arst_rf_we", rf_we, 0);
        check("arst_mask", pending_mask, 0);
        check("arst_stall", pipe_stall, 0);
        pipe_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", slow_ready, 1);
        check("post_rst_we", rf_we, 0);
        tick();
        check("post_rst_empty_we", rf_we, 0);
        check("post_rst_empty_mask", pending_mask, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
